// File: rtl/fxyz_sweeper.sv
// Sweeps all eight {X,Y,Z} vectors into a 3-input function block, captures S1 into a truth table
// and scores it against a latched expected table.
module fxyz_sweeper #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] exp_tbl,
  input  logic       S1,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       busy,
  output logic       done,
  output logic [7:0] tbl,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] first_err
);

  localparam logic [3:0] LastCnt = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e     r_state, w_state_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic [2:0] r_xyz, w_xyz_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_exp, w_exp_nxt;
  logic [7:0] r_tbl, w_tbl_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       r_pass, w_pass_nxt;
  logic [3:0] r_err, w_err_nxt;
  logic [2:0] r_first, w_first_nxt;
  logic       w_mis;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_xyz_nxt   = r_xyz;
    w_cnt_nxt   = r_cnt;
    w_exp_nxt   = r_exp;
    w_tbl_nxt   = r_tbl;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    w_err_nxt   = r_err;
    w_first_nxt = r_first;
    w_mis       = 1'b0;

    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_idx_nxt   = 3'd0;
          w_xyz_nxt   = 3'd0;
          w_exp_nxt   = exp_tbl;
          w_tbl_nxt   = 8'h00;
          w_err_nxt   = 4'd0;
          w_first_nxt = 3'd0;
          w_pass_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = StSettle;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      StSettle: begin
        if (r_cnt == LastCnt) begin
          w_state_nxt = StSample;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      StSample: begin
        w_mis            = (S1 != r_exp[r_idx]);
        w_tbl_nxt[r_idx] = S1;
        if (w_mis) begin
          w_err_nxt = r_err + 4'd1;
          if (r_err == 4'd0) begin
            w_first_nxt = r_idx;
          end
        end
        if (r_idx == 3'd7) begin
          w_state_nxt = StDone;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_err_nxt == 4'd0);
          w_xyz_nxt   = 3'd0;
        end else begin
          w_idx_nxt   = r_idx + 3'd1;
          w_xyz_nxt   = r_idx + 3'd1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = StSettle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_idx   <= 3'd0;
      r_xyz   <= 3'd0;
      r_cnt   <= 4'd0;
      r_exp   <= 8'h00;
      r_tbl   <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 4'd0;
      r_first <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_xyz   <= w_xyz_nxt;
      r_cnt   <= w_cnt_nxt;
      r_exp   <= w_exp_nxt;
      r_tbl   <= w_tbl_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_err   <= w_err_nxt;
      r_first <= w_first_nxt;
    end
  end

  assign X         = r_xyz[2];
  assign Y         = r_xyz[1];
  assign Z         = r_xyz[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign tbl       = r_tbl;
  assign pass      = r_pass;
  assign err_cnt   = r_err;
  assign first_err = r_first;

endmodule

// File: tb/tb_fxyz_sweeper.sv
// Bench for fxyz_sweeper: two instances (default settle and SETTLE_CYC=1) driving a bench-side
// function block, with table vectors, corner-case sequences and randomized sweeps.
module tb_fxyz_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, sel, use_formula;
  logic [7:0] exp_tbl, fn_tbl;

  logic       a_x, a_y, a_z, a_busy, a_done, a_pass, a_s1, a_start;
  logic [7:0] a_tbl;
  logic [3:0] a_err;
  logic [2:0] a_first;
  logic       b_x, b_y, b_z, b_busy, b_done, b_pass, b_s1, b_start;
  logic [7:0] b_tbl;
  logic [3:0] b_err;
  logic [2:0] b_first;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic fxyz(input logic x, input logic y, input logic z);
    return (x | ~y | ~z) & (~x | y | ~z) & (~x | y | z);
  endfunction

  assign a_s1    = use_formula ? fxyz(a_x, a_y, a_z) : fn_tbl[{a_x, a_y, a_z}];
  assign b_s1    = use_formula ? fxyz(b_x, b_y, b_z) : fn_tbl[{b_x, b_y, b_z}];
  assign a_start = start & ~sel;
  assign b_start = start & sel;

  fxyz_sweeper u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .exp_tbl(exp_tbl), .S1(a_s1),
    .X(a_x), .Y(a_y), .Z(a_z), .busy(a_busy), .done(a_done), .tbl(a_tbl),
    .pass(a_pass), .err_cnt(a_err), .first_err(a_first)
  );

  fxyz_sweeper #(.SETTLE_CYC(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .exp_tbl(exp_tbl), .S1(b_s1),
    .X(b_x), .Y(b_y), .Z(b_z), .busy(b_busy), .done(b_done), .tbl(b_tbl),
    .pass(b_pass), .err_cnt(b_err), .first_err(b_first)
  );

  logic [2:0] cur_xyz, cur_first;
  logic       cur_busy, cur_done, cur_pass;
  logic [7:0] cur_tbl;
  logic [3:0] cur_err;
  assign cur_xyz   = sel ? {b_x, b_y, b_z} : {a_x, a_y, a_z};
  assign cur_busy  = sel ? b_busy : a_busy;
  assign cur_done  = sel ? b_done : a_done;
  assign cur_tbl   = sel ? b_tbl : a_tbl;
  assign cur_pass  = sel ? b_pass : a_pass;
  assign cur_err   = sel ? b_err : a_err;
  assign cur_first = sel ? b_first : a_first;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: score a function table against an expected table from first principles.
  task automatic model(input logic uf, input logic [7:0] fn, input logic [7:0] e,
                       output logic [7:0] t, output logic p, output int err, output int first);
    t = 8'h00;
    err = 0;
    first = -1;
    for (int v = 0; v < 8; v++) begin
      t[v] = uf ? fxyz(v[2], v[1], v[0]) : fn[v];
      if (t[v] != e[v]) begin
        err++;
        if (first < 0) first = v;
      end
    end
    if (first < 0) first = 0;
    p = (err == 0);
  endtask

  // Pulse start, then walk the sweep cycle by cycle until done (bounded).
  task automatic run_sweep(input logic [7:0] e, input int chg_at, output int lat,
                           output logic xyz_ok);
    int per;
    per = sel ? 2 : 3;
    @(negedge clk);
    exp_tbl = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(cur_busy), 32'd1);
    xyz_ok = 1'b1;
    lat = -1;
    for (int c = 0; c < 200; c++) begin
      if (cur_done) begin
        lat = c;
        break;
      end
      if (cur_xyz != 3'(c / per)) xyz_ok = 1'b0;
      if (c == chg_at) exp_tbl = 8'h00;
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      @(negedge clk);
    end
    chk("busy_low_at_done", 32'(cur_busy), 32'd0);
  endtask

  typedef struct {
    logic       uf;
    logic [7:0] fn;
    logic [7:0] e;
    int         chg;
    logic [7:0] t;
    logic       p;
    int         err;
    int         first;
  } vec_t;

  vec_t vecs[6];
  int lat, d, m_err, m_first;
  logic xyz_ok, m_p;
  logic [7:0] m_t;

  initial begin
    vecs[0] = '{1'b1, 8'h00, 8'hC7, -1, 8'hC7, 1'b1, 0, 0};
    vecs[1] = '{1'b1, 8'h00, 8'hFF, 10, 8'hC7, 1'b0, 3, 3};
    vecs[2] = '{1'b0, 8'h00, 8'hFF, -1, 8'h00, 1'b0, 8, 0};
    vecs[3] = '{1'b1, 8'h00, 8'h00, -1, 8'hC7, 1'b0, 5, 0};
    vecs[4] = '{1'b0, 8'hFF, 8'h7F, -1, 8'hFF, 1'b0, 1, 7};
    vecs[5] = '{1'b0, 8'hA5, 8'hA5, -1, 8'hA5, 1'b1, 0, 0};

    rst_n = 1'b0; start = 1'b0; sel = 1'b0; use_formula = 1'b1;
    exp_tbl = 8'h00; fn_tbl = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_a", 32'({a_x, a_y, a_z, a_busy, a_done, a_tbl, a_pass, a_err, a_first}), 32'd0);
    chk("reset_b", 32'({b_x, b_y, b_z, b_busy, b_done, b_tbl, b_pass, b_err, b_first}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      use_formula = vecs[i].uf;
      fn_tbl = vecs[i].fn;
      run_sweep(vecs[i].e, vecs[i].chg, lat, xyz_ok);
      chk("vec_latency", 32'(lat), 32'd24);
      chk("vec_xyz_seq", 32'(xyz_ok), 32'd1);
      chk("vec_tbl", 32'(cur_tbl), 32'(vecs[i].t));
      chk("vec_pass", 32'(cur_pass), 32'(vecs[i].p));
      chk("vec_err_cnt", 32'(cur_err), 32'(vecs[i].err));
      chk("vec_first_err", 32'(cur_first), 32'(vecs[i].first));
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(a_done), 32'd0);
    chk("result_held", 32'({a_tbl, a_pass, a_err, a_first}), 32'({8'hA5, 1'b1, 4'd0, 3'd0}));

    // SETTLE_CYC=1 instance
    sel = 1'b1; use_formula = 1'b1;
    run_sweep(8'hC7, -1, lat, xyz_ok);
    chk("s1_latency", 32'(lat), 32'd16);
    chk("s1_xyz_seq", 32'(xyz_ok), 32'd1);
    chk("s1_tbl", 32'(b_tbl), 32'hC7);
    chk("s1_pass", 32'(b_pass), 32'd1);
    sel = 1'b0;

    // Start held high: back-to-back sweeps with one idle cycle of busy.
    @(negedge clk);
    exp_tbl = 8'hC7; start = 1'b1;
    d = 0;
    while (!a_done && d < 100) begin
      @(negedge clk);
      d++;
    end
    chk("hold_first_done", 32'(a_done), 32'd1);
    chk("hold_busy_gap", 32'(a_busy), 32'd0);
    @(negedge clk);
    chk("hold_restart_busy", 32'(a_busy), 32'd1);
    d = 1;
    while (!a_done && d < 100) begin
      @(negedge clk);
      d++;
    end
    start = 1'b0;
    chk("hold_period", 32'(d), 32'd25);
    chk("hold_tbl", 32'(a_tbl), 32'hC7);
    @(negedge clk);
    chk("hold_release_idle", 32'(a_busy), 32'd0);

    // Reset mid-sweep
    exp_tbl = 8'hC7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid", 32'({a_x, a_y, a_z, a_busy, a_done, a_tbl, a_pass, a_err, a_first}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_stays_idle", 32'(a_busy), 32'd0);
    run_sweep(8'hC7, -1, lat, xyz_ok);
    chk("post_reset_latency", 32'(lat), 32'd24);
    chk("post_reset_tbl", 32'(a_tbl), 32'hC7);

    // Randomized sweeps against the reference model
    for (int r = 0; r < 16; r++) begin
      sel = 1'($urandom);
      use_formula = ($urandom_range(0, 3) == 0);
      fn_tbl = 8'($urandom);
      exp_tbl = 8'($urandom);
      model(use_formula, fn_tbl, exp_tbl, m_t, m_p, m_err, m_first);
      run_sweep(exp_tbl, -1, lat, xyz_ok);
      chk("rnd_latency", 32'(lat), sel ? 32'd16 : 32'd24);
      chk("rnd_xyz_seq", 32'(xyz_ok), 32'd1);
      chk("rnd_tbl", 32'(cur_tbl), 32'(m_t));
      chk("rnd_pass", 32'(cur_pass), 32'(m_p));
      chk("rnd_err_cnt", 32'(cur_err), 32'(m_err));
      chk("rnd_first_err", 32'(cur_first), 32'(m_first));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
